// File: rtl/register_tree_kv_cycled_pkg.sv
// Shared types for the cycled key/value register-tree priority queue.
package register_tree_pkg;

    typedef enum logic {PHASE_EVEN, PHASE_ODD} phase_e;

    typedef enum logic [2:0] {OP_IDLE, OP_ENQ, OP_DEQ, OP_REPL, OP_DROP} op_e;

    // Tree level of a node index (root is level 0).
    function automatic int unsigned node_level(input int unsigned idx);
        return $clog2(idx + 2) - 1;
    endfunction

endpackage

// File: rtl/register_tree_kv_cycled_cas3.sv
// Combinational compare-swap of one parent node with its two children.
module register_tree_cas3 #(
    parameter int unsigned KEY_WIDTH = 16,
    parameter int unsigned VAL_WIDTH = 8,
    parameter bit          MIN_FIRST = 1'b0
) (
    input  logic [KEY_WIDTH+VAL_WIDTH:0] parent,
    input  logic [KEY_WIDTH+VAL_WIDTH:0] left,
    input  logic [KEY_WIDTH+VAL_WIDTH:0] right,
    output logic [KEY_WIDTH+VAL_WIDTH:0] new_parent,
    output logic [KEY_WIDTH+VAL_WIDTH:0] new_left,
    output logic [KEY_WIDTH+VAL_WIDTH:0] new_right
);

    localparam int unsigned VB = KEY_WIDTH + VAL_WIDTH;

    // Node layout is {valid, key, val}; strict comparison keeps ties in place.
    function automatic logic beats(input logic [VB:0] a, input logic [VB:0] b);
        logic [KEY_WIDTH-1:0] ka;
        logic [KEY_WIDTH-1:0] kb;
        ka = a[VB-1 -: KEY_WIDTH];
        kb = b[VB-1 -: KEY_WIDTH];
        return a[VB] && (!b[VB] || (MIN_FIRST ? (ka < kb) : (ka > kb)));
    endfunction

    logic            right_wins;
    logic [VB:0]     winner;

    always_comb begin
        right_wins = beats(right, left);
        winner     = right_wins ? right : left;
        new_parent = parent;
        new_left   = left;
        new_right  = right;
        if (beats(winner, parent)) begin
            new_parent = winner;
            if (right_wins) new_right = parent;
            else            new_left  = parent;
        end
    end

endmodule

// File: rtl/register_tree_kv_cycled.sv
// Key/value priority queue in a register tree; alternating-level compare-swaps settle the
// best entry into the root while no request is in flight.
module register_tree_kv_cycled
    import register_tree_pkg::*;
#(
    parameter int unsigned QUEUE_SIZE = 15,
    parameter int unsigned KEY_WIDTH  = 16,
    parameter int unsigned VAL_WIDTH  = 8,
    parameter bit          MIN_FIRST  = 1'b0,
    parameter bit          ENQ_ENA    = 1'b1
) (
    input  logic                              i_CLK,
    input  logic                              i_RSTn,
    input  logic                              i_wrt,
    input  logic                              i_read,
    input  logic [KEY_WIDTH-1:0]              i_key,
    input  logic [VAL_WIDTH-1:0]              i_val,
    output logic [KEY_WIDTH-1:0]              o_key,
    output logic [VAL_WIDTH-1:0]              o_val,
    output logic [$clog2(QUEUE_SIZE+1)-1:0]   o_size,
    output logic                              o_full,
    output logic                              o_empty,
    output logic                              o_stable,
    output logic                              o_drop
);

    localparam int unsigned TREE_DEPTH = $clog2(QUEUE_SIZE + 1);
    localparam int unsigned NODES      = (1 << TREE_DEPTH) - 1;
    localparam int unsigned PARENTS    = (1 << (TREE_DEPTH - 1)) - 1;
    localparam int unsigned PAR_N      = (PARENTS > 0) ? PARENTS : 1;
    localparam int unsigned CNT_W      = $clog2(2 * TREE_DEPTH + 1);
    localparam logic [CNT_W-1:0] SETTLE = CNT_W'(2 * TREE_DEPTH);

    typedef struct packed {
        logic                 valid;
        logic [KEY_WIDTH-1:0] key;
        logic [VAL_WIDTH-1:0] val;
    } node_t;

    node_t                   nodes_q    [NODES];
    node_t                   nodes_swap [NODES];
    node_t                   cas_p      [PAR_N];
    node_t                   cas_l      [PAR_N];
    node_t                   cas_r      [PAR_N];
    logic [TREE_DEPTH-1:0]   size_q;
    logic [CNT_W-1:0]        cnt_q;
    phase_e                  phase_q;
    logic                    drop_q;
    logic [TREE_DEPTH-1:0]   free_idx;
    logic                    full;
    logic                    empty;
    op_e                     op;

    for (genvar g = 0; g < PARENTS; g++) begin : g_cas
        register_tree_cas3 #(
            .KEY_WIDTH (KEY_WIDTH),
            .VAL_WIDTH (VAL_WIDTH),
            .MIN_FIRST (MIN_FIRST)
        ) u_cas (
            .parent     (nodes_q[g]),
            .left       (nodes_q[2*g+1]),
            .right      (nodes_q[2*g+2]),
            .new_parent (cas_p[g]),
            .new_left   (cas_l[g]),
            .new_right  (cas_r[g])
        );
    end

    // Triples on same-parity levels never share nodes, so one phase applies them all at once.
    always_comb begin
        nodes_swap = nodes_q;
        for (int i = 0; i < PARENTS; i++) begin
            if ((node_level(i) % 2 == 1) == (phase_q == PHASE_ODD)) begin
                nodes_swap[i]     = cas_p[i];
                nodes_swap[2*i+1] = cas_l[i];
                nodes_swap[2*i+2] = cas_r[i];
            end
        end
    end

    always_comb begin
        free_idx = '0;
        for (int i = NODES - 1; i >= 0; i--) begin
            if (!nodes_q[i].valid) free_idx = TREE_DEPTH'(i);
        end
    end

    assign full  = (size_q == TREE_DEPTH'(QUEUE_SIZE));
    assign empty = (size_q == '0);

    always_comb begin
        op = OP_IDLE;
        if (i_wrt && i_read)  op = OP_REPL;
        else if (i_wrt)       op = (ENQ_ENA && !full) ? OP_ENQ : OP_DROP;
        else if (i_read)      op = empty ? OP_DROP : OP_DEQ;
    end

    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) begin
            for (int i = 0; i < NODES; i++) nodes_q[i] <= '0;
            size_q  <= '0;
            cnt_q   <= '0;
            phase_q <= PHASE_EVEN;
            drop_q  <= 1'b0;
        end else begin
            drop_q <= (op == OP_DROP);
            unique case (op)
                OP_ENQ: begin
                    nodes_q[free_idx] <= node_t'{valid: 1'b1, key: i_key, val: i_val};
                    size_q            <= size_q + 1'b1;
                    cnt_q             <= SETTLE;
                    phase_q           <= PHASE_EVEN;
                end
                OP_DEQ: begin
                    nodes_q[0] <= '0;
                    size_q     <= size_q - 1'b1;
                    cnt_q      <= SETTLE;
                    phase_q    <= PHASE_EVEN;
                end
                OP_REPL: begin
                    nodes_q[0] <= node_t'{valid: 1'b1, key: i_key, val: i_val};
                    if (empty) size_q <= TREE_DEPTH'(1);
                    cnt_q      <= SETTLE;
                    phase_q    <= PHASE_EVEN;
                end
                OP_IDLE: begin
                    nodes_q <= nodes_swap;
                    cnt_q   <= (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
                    phase_q <= (phase_q == PHASE_EVEN) ? PHASE_ODD : PHASE_EVEN;
                end
                default: ;  // rejected request: only the drop flag moves
            endcase
        end
    end

    assign o_key    = nodes_q[0].key;
    assign o_val    = nodes_q[0].val;
    assign o_size   = size_q;
    assign o_full   = full;
    assign o_empty  = empty;
    assign o_stable = (cnt_q == '0);
    assign o_drop   = drop_q;

endmodule

// File: tb/tb_register_tree_kv_cycled.sv
// Scoreboard bench: dut0 max-first, dut1 min-first, dut2 with enqueue disabled.
module tb_register_tree_kv_cycled;

    typedef struct {
        logic [7:0] key;
        logic [3:0] val;
        logic [2:0] size;
    } exp_t;

    logic       clk;
    logic       rstn;
    logic       in_wrt  [3];
    logic       in_read [3];
    logic [7:0] in_key  [3];
    logic [3:0] in_val  [3];

    logic [7:0] k0, k1, k2;
    logic [3:0] v0, v1, v2;
    logic [2:0] s0, s1, s2;
    logic       fu0, fu1, fu2, em0, em1, em2, st0, st1, st2, dr0, dr1, dr2;

    logic [7:0] obs_key    [3];
    logic [3:0] obs_val    [3];
    logic [2:0] obs_size   [3];
    logic       obs_full   [3];
    logic       obs_empty  [3];
    logic       obs_stable [3];
    logic       obs_drop   [3];

    int   n_checks;
    int   n_fail;
    int   m_key [$];
    int   m_val [$];
    exp_t sb    [$];

    register_tree_kv_cycled #(.QUEUE_SIZE(7), .KEY_WIDTH(8), .VAL_WIDTH(4), .MIN_FIRST(1'b0),
                              .ENQ_ENA(1'b1)) dut0 (
        .i_CLK(clk), .i_RSTn(rstn), .i_wrt(in_wrt[0]), .i_read(in_read[0]), .i_key(in_key[0]),
        .i_val(in_val[0]), .o_key(k0), .o_val(v0), .o_size(s0), .o_full(fu0), .o_empty(em0),
        .o_stable(st0), .o_drop(dr0));

    register_tree_kv_cycled #(.QUEUE_SIZE(7), .KEY_WIDTH(8), .VAL_WIDTH(4), .MIN_FIRST(1'b1),
                              .ENQ_ENA(1'b1)) dut1 (
        .i_CLK(clk), .i_RSTn(rstn), .i_wrt(in_wrt[1]), .i_read(in_read[1]), .i_key(in_key[1]),
        .i_val(in_val[1]), .o_key(k1), .o_val(v1), .o_size(s1), .o_full(fu1), .o_empty(em1),
        .o_stable(st1), .o_drop(dr1));

    register_tree_kv_cycled #(.QUEUE_SIZE(7), .KEY_WIDTH(8), .VAL_WIDTH(4), .MIN_FIRST(1'b0),
                              .ENQ_ENA(1'b0)) dut2 (
        .i_CLK(clk), .i_RSTn(rstn), .i_wrt(in_wrt[2]), .i_read(in_read[2]), .i_key(in_key[2]),
        .i_val(in_val[2]), .o_key(k2), .o_val(v2), .o_size(s2), .o_full(fu2), .o_empty(em2),
        .o_stable(st2), .o_drop(dr2));

    always_comb begin
        obs_key[0] = k0;   obs_key[1] = k1;   obs_key[2] = k2;
        obs_val[0] = v0;   obs_val[1] = v1;   obs_val[2] = v2;
        obs_size[0] = s0;  obs_size[1] = s1;  obs_size[2] = s2;
        obs_full[0] = fu0; obs_full[1] = fu1; obs_full[2] = fu2;
        obs_empty[0] = em0; obs_empty[1] = em1; obs_empty[2] = em2;
        obs_stable[0] = st0; obs_stable[1] = st1; obs_stable[2] = st2;
        obs_drop[0] = dr0; obs_drop[1] = dr1; obs_drop[2] = dr2;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int d, input logic w, input logic r, input logic [7:0] k,
                         input logic [3:0] v);
        in_wrt[d]  = w;
        in_read[d] = r;
        in_key[d]  = k;
        in_val[d]  = v;
        tick();
        in_wrt[d]  = 1'b0;
        in_read[d] = 1'b0;
    endtask

    task automatic pulse_reset();
        rstn = 1'b0;
        #2;
        rstn = 1'b1;
        tick();
        m_key.delete();
        m_val.delete();
        sb.delete();
    endtask

    function automatic int best(input bit minf);
        int b = 0;
        for (int i = 1; i < m_key.size(); i++)
            if (minf ? (m_key[i] < m_key[b]) : (m_key[i] > m_key[b])) b = i;
        return b;
    endfunction

    task automatic push_exp(input bit minf);
        int b = best(minf);
        sb.push_back('{key: 8'(m_key[b]), val: 4'(m_val[b]), size: 3'(m_key.size())});
    endtask

    task automatic enq_model(input int d, input int k, input int v);
        drive(d, 1'b1, 1'b0, 8'(k), 4'(v));
        m_key.push_back(k);
        m_val.push_back(v);
    endtask

    task automatic wait_stable(input int d, output int drops);
        bit ok = 1'b0;
        drops = 0;
        for (int c = 0; c < 40; c++) begin
            if (obs_stable[d]) begin
                ok = 1'b1;
                break;
            end
            drops += int'(obs_drop[d]);
            tick();
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL stable_timeout dut%0d: o_stable got 0 required 1", d);
        end
    endtask

    task automatic test_reset();
        for (int d = 0; d < 3; d++) begin
            n_checks++;
            if ({obs_key[d], obs_val[d], obs_size[d], obs_empty[d], obs_full[d], obs_stable[d],
                 obs_drop[d]} !== {8'd0, 4'd0, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL reset dut%0d: key=%0d val=%0d size=%0d e/f/s/d=%b%b%b%b required 0 0 0 1010",
                         d, obs_key[d], obs_val[d], obs_size[d], obs_empty[d], obs_full[d],
                         obs_stable[d], obs_drop[d]);
            end
        end
    endtask

    task automatic test_order();
        int   drops = 0;
        int   w;
        exp_t e;
        pulse_reset();
        enq_model(0, 3, 1);
        drops += int'(obs_drop[0]);
        enq_model(0, 9, 2);
        drops += int'(obs_drop[0]);
        enq_model(0, 5, 3);
        drops += int'(obs_drop[0]);
        n_checks++;
        if (obs_stable[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL order_unstable: o_stable got %b required 0", obs_stable[0]);
        end
        push_exp(1'b0);
        wait_stable(0, w);
        drops += w;
        e = sb.pop_front();
        n_checks++;
        if ({obs_key[0], obs_val[0], obs_size[0]} !== {e.key, e.val, e.size}) begin
            n_fail++;
            $display("FAIL order_root: key/val/size got %0d/%0d/%0d required %0d/%0d/%0d",
                     obs_key[0], obs_val[0], obs_size[0], e.key, e.val, e.size);
        end
        n_checks++;
        if (drops !== 0) begin
            n_fail++;
            $display("FAIL order_drop: drop pulses got %0d required 0", drops);
        end
    endtask

    task automatic test_full();
        int   w;
        int   keys [7] = '{20, 7, 33, 2, 15, 41, 9};
        exp_t e;
        pulse_reset();
        for (int i = 0; i < 7; i++) enq_model(0, keys[i], i + 1);
        push_exp(1'b0);
        wait_stable(0, w);
        e = sb.pop_front();
        n_checks++;
        if ({obs_key[0], obs_val[0], obs_size[0], obs_full[0]} !== {e.key, e.val, e.size, 1'b1}) begin
            n_fail++;
            $display("FAIL full_root: key/val/size/full got %0d/%0d/%0d/%b required %0d/%0d/%0d/1",
                     obs_key[0], obs_val[0], obs_size[0], obs_full[0], e.key, e.val, e.size);
        end
        drive(0, 1'b1, 1'b0, 8'd99, 4'd1);
        push_exp(1'b0);
        n_checks++;
        if ({obs_drop[0], obs_size[0], obs_full[0]} !== {1'b1, 3'd7, 1'b1}) begin
            n_fail++;
            $display("FAIL full_drop: drop/size/full got %b/%0d/%b required 1/7/1",
                     obs_drop[0], obs_size[0], obs_full[0]);
        end
        e = sb.pop_front();
        n_checks++;
        if ({obs_key[0], obs_val[0]} !== {e.key, e.val}) begin
            n_fail++;
            $display("FAIL full_root_kept: key/val got %0d/%0d required %0d/%0d",
                     obs_key[0], obs_val[0], e.key, e.val);
        end
        tick();
        n_checks++;
        if (obs_drop[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL full_drop_width: o_drop got %b required 0", obs_drop[0]);
        end
    endtask

    task automatic test_empty();
        exp_t e;
        pulse_reset();
        drive(0, 1'b0, 1'b1, 8'd0, 4'd0);
        n_checks++;
        if ({obs_drop[0], obs_empty[0], obs_size[0]} !== {1'b1, 1'b1, 3'd0}) begin
            n_fail++;
            $display("FAIL empty_deq: drop/empty/size got %b/%b/%0d required 1/1/0",
                     obs_drop[0], obs_empty[0], obs_size[0]);
        end
        enq_model(0, 0, 5);
        push_exp(1'b0);
        e = sb.pop_front();
        n_checks++;
        if ({obs_empty[0], obs_drop[0], obs_key[0], obs_val[0], obs_size[0]} !==
            {1'b0, 1'b0, e.key, e.val, e.size}) begin
            n_fail++;
            $display("FAIL key_zero: empty/drop/key/val/size got %b/%b/%0d/%0d/%0d required 0/0/%0d/%0d/%0d",
                     obs_empty[0], obs_drop[0], obs_key[0], obs_val[0], obs_size[0],
                     e.key, e.val, e.size);
        end
    endtask

    task automatic test_min_first();
        int   w;
        int   b;
        exp_t e;
        pulse_reset();
        enq_model(1, 40, 1);
        enq_model(1, 10, 2);
        enq_model(1, 25, 3);
        for (int n = 0; n < 3; n++) begin
            wait_stable(1, w);
            push_exp(1'b1);
            e = sb.pop_front();
            n_checks++;
            if ({obs_key[1], obs_val[1], obs_size[1]} !== {e.key, e.val, e.size}) begin
                n_fail++;
                $display("FAIL min_first_%0d: key/val/size got %0d/%0d/%0d required %0d/%0d/%0d",
                         n, obs_key[1], obs_val[1], obs_size[1], e.key, e.val, e.size);
            end
            drive(1, 1'b0, 1'b1, 8'd0, 4'd0);
            b = best(1'b1);
            m_key.delete(b);
            m_val.delete(b);
        end
        n_checks++;
        if ({obs_empty[1], obs_size[1]} !== {1'b1, 3'd0}) begin
            n_fail++;
            $display("FAIL min_first_empty: empty/size got %b/%0d required 1/0",
                     obs_empty[1], obs_size[1]);
        end
    endtask

    task automatic test_replace();
        int   w;
        int   b;
        exp_t e;
        pulse_reset();
        for (int k = 1; k <= 7; k++) enq_model(0, k, k);
        wait_stable(0, w);
        drive(0, 1'b1, 1'b1, 8'd0, 4'd0);
        b = best(1'b0);
        m_key[b] = 0;
        m_val[b] = 0;
        push_exp(1'b0);
        wait_stable(0, w);
        e = sb.pop_front();
        n_checks++;
        if ({obs_key[0], obs_val[0], obs_size[0]} !== {e.key, e.val, e.size}) begin
            n_fail++;
            $display("FAIL replace: key/val/size got %0d/%0d/%0d required %0d/%0d/%0d",
                     obs_key[0], obs_val[0], obs_size[0], e.key, e.val, e.size);
        end
    endtask

    task automatic test_enq_disabled();
        pulse_reset();
        drive(2, 1'b1, 1'b1, 8'd12, 4'd3);
        n_checks++;
        if ({obs_key[2], obs_val[2], obs_size[2], obs_drop[2]} !== {8'd12, 4'd3, 3'd1, 1'b0}) begin
            n_fail++;
            $display("FAIL repl_empty: key/val/size/drop got %0d/%0d/%0d/%b required 12/3/1/0",
                     obs_key[2], obs_val[2], obs_size[2], obs_drop[2]);
        end
        drive(2, 1'b1, 1'b0, 8'd50, 4'd1);
        n_checks++;
        if ({obs_drop[2], obs_size[2], obs_key[2]} !== {1'b1, 3'd1, 8'd12}) begin
            n_fail++;
            $display("FAIL enq_disabled: drop/size/key got %b/%0d/%0d required 1/1/12",
                     obs_drop[2], obs_size[2], obs_key[2]);
        end
        drive(2, 1'b0, 1'b1, 8'd0, 4'd0);
        n_checks++;
        if ({obs_drop[2], obs_empty[2], obs_size[2]} !== {1'b0, 1'b1, 3'd0}) begin
            n_fail++;
            $display("FAIL deq_disabled_enq: drop/empty/size got %b/%b/%0d required 0/1/0",
                     obs_drop[2], obs_empty[2], obs_size[2]);
        end
    endtask

    task automatic test_reset_mid_settle();
        int   w;
        exp_t e;
        pulse_reset();
        enq_model(0, 5, 1);
        enq_model(0, 8, 2);
        tick();
        n_checks++;
        if (obs_stable[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL settle_window: o_stable got %b required 0", obs_stable[0]);
        end
        rstn = 1'b0;
        #2;
        rstn = 1'b1;
        tick();
        m_key.delete();
        m_val.delete();
        test_reset();
        enq_model(0, 3, 3);
        push_exp(1'b0);
        wait_stable(0, w);
        e = sb.pop_front();
        n_checks++;
        if ({obs_key[0], obs_val[0], obs_size[0]} !== {e.key, e.val, e.size}) begin
            n_fail++;
            $display("FAIL post_reset_enq: key/val/size got %0d/%0d/%0d required %0d/%0d/%0d",
                     obs_key[0], obs_val[0], obs_size[0], e.key, e.val, e.size);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        for (int d = 0; d < 3; d++) begin
            in_wrt[d]  = 1'b0;
            in_read[d] = 1'b0;
            in_key[d]  = '0;
            in_val[d]  = '0;
        end
        rstn = 1'b0;
        #7;
        rstn = 1'b1;
        tick();
        test_reset();
        test_order();
        test_full();
        test_empty();
        test_min_first();
        test_replace();
        test_enq_disabled();
        test_reset_mid_settle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
